cache_controller: RTL and testbench
===================================

# cache_controller

Sequencing controller for the cache data array: a direct-mapped, write-back, write-allocate cache controller. It accepts single-word CPU requests, keeps the tag, valid and dirty state, and drives the data array's word port (A) for CPU hits and its line port (B) for victim readout and line fill. It also talks to the next memory level over a line-wide valid/ready interface.

## Interface
- DATA_WIDTH, 32, word width
- INDEX_WIDTH, 9, line index bits (2**INDEX_WIDTH lines)
- WORD_BITS, 3, word-in-line bits (2**WORD_BITS words per line)
- ADDR_WIDTH, 32, CPU word-address width

Ports:
- clk  in  1  clock, single domain
- reset  in  1  synchronous, active-high
- cpu_req_valid / cpu_req_ready  in / out  1  CPU request handshake
- cpu_req_we  in  1  write request when 1
- cpu_req_addr  in  ADDR_WIDTH  word address: {tag, index, word}
- cpu_req_wdata  in  DATA_WIDTH  write data
- cpu_resp_valid  out  1  one-cycle response pulse, once per accepted request
- cpu_resp_rdata  out  DATA_WIDTH  read data (write data echoed on writes)
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_we  out  1  line writeback when 1, line fill when 0
- mem_req_addr  out  ADDR_WIDTH-WORD_BITS  line address {tag, index}
- mem_req_wdata  out  LINE_WIDTH  victim line
- mem_resp_valid  in  1  fill data valid (reads only)
- mem_resp_rdata  in  LINE_WIDTH  fill line, word 0 in LSBs
- arr_addr_a, arr_word_a, arr_data_a, arr_we_a  out  INDEX_WIDTH, WORD_BITS, DATA_WIDTH, 1  data-array port A
- arr_q_a  in  DATA_WIDTH  port A read data, 1-cycle latency
- arr_addr_b, arr_data_b, arr_we_b  out  INDEX_WIDTH, LINE_WIDTH, 1  data-array port B
- arr_q_b  in  LINE_WIDTH  port B read data, 1-cycle latency

## Operation
- LINE_WIDTH = DATA_WIDTH*2**WORD_BITS.
- TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-WORD_BITS.
- **IDLE**: cpu_req_ready=1. Ports A and B are driven combinationally from cpu_req_addr as reads. On accept, the request is latched and the state moves to LOOKUP.
- **LOOKUP**: compares the latched tag with the stored tag and the valid bit. Ports are now driven from the latched request.
  - Read hit: cpu_resp_valid=1 with rdata=arr_q_a; go to IDLE.
  - Write hit: arr_we_a=1 with latched data, dirty[index] set, cpu_resp_valid=1; go to IDLE.
  - Miss with a valid, dirty line: latch arr_q_b into the victim buffer; go to WB_REQ.
  - Any other miss: go to FILL_REQ.
- **WB_REQ**: mem_req_valid=1, we=1, addr={old tag, index}, wdata=victim buffer. On ready, go to FILL_REQ.
- **FILL_REQ**: mem_req_valid=1, we=0, addr={latched tag, index}. On ready, go to FILL_WAIT.
- **FILL_WAIT**: on mem_resp_valid, arr_we_b=1 with arr_data_b=mem_resp_rdata. Tag is written, valid=1, dirty=0. Go to REPLAY.
- **REPLAY**: issues a port-A read of the latched request, then goes to LOOKUP, which is then guaranteed to hit.
- arr_we_a and arr_we_b are never asserted in the same cycle.
- mem_req_* fields are held stable while mem_req_valid=1 and ready=0.
- mem_resp_valid outside FILL_WAIT is ignored.

## Timing
- Reset:
  - state IDLE; all valid and dirty bits cleared.
  - cpu_req_ready=0 while reset=1, and 1 in the first cycle after reset is released.
  - All other outputs are 0.
- Reset mid-operation aborts the transaction; mem_req_valid is 0 in the cycle after the reset edge, and the pending CPU request gets no response.
- Hit latency: accept at edge T, cpu_resp_valid in cycle T+1.
- Clean miss: FILL_REQ in T+2. Response two cycles after the mem_resp_valid cycle (REPLAY, then LOOKUP).
- Dirty miss adds the WB_REQ handshake, minimum 1 cycle.
- One outstanding request; cpu_req_ready=0 in every state except IDLE.
- Index and tag are taken bit-exact from the address; no wrap or arithmetic beyond field slicing.

## Structure
- Package cache_pkg holds:
  - the state enum (IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, REPLAY);
  - localparams TAG_WIDTH and LINE_WIDTH;
  - address-field slicing functions.
- Sub-module tag_store holds the tag register array plus valid and dirty vectors. It has:
  - a synchronous clear on reset;
  - a combinational read by index;
  - a write port for fills and for dirty set.

## Test plan
- After reset, read 0x100: mem read request at line 0x20. Respond with a line where word k=0x1000+k. Required: cpu_resp_rdata=0x1000, and no writeback.
- Then read 0x103: hit, cpu_resp_valid one cycle after accept, rdata=0x1003, mem_req_valid stays 0.
- Write 0x105 with 0xDEADBEEF: hit, response next cycle. A following read of 0x105 returns 0xDEADBEEF.
- Read 0x1100 (index 0x20, tag 1): first a writeback to line 0x20 with word3=0x1003 and word5=0xDEADBEEF, then a fill request at line 0x220.
- Hold mem_req_ready=0 for 10 cycles during WB_REQ: valid, addr and wdata stay constant, and cpu_req_ready stays 0.
- Assert reset in FILL_WAIT: mem_req_valid=0 next cycle, cpu_req_ready=1 after release, and a read of 0x100 misses again.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared types and address helpers for the direct-mapped write-back cache controller.
package cache_pkg;

  localparam int CFG_DATA_WIDTH  = 32;
  localparam int CFG_INDEX_WIDTH = 9;
  localparam int CFG_WORD_BITS   = 3;
  localparam int CFG_ADDR_WIDTH  = 32;

  localparam int TAG_WIDTH  = CFG_ADDR_WIDTH - CFG_INDEX_WIDTH - CFG_WORD_BITS;
  localparam int LINE_WIDTH = CFG_DATA_WIDTH * (2 ** CFG_WORD_BITS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT,
    REPLAY
  } state_e;

  // Word address layout is {tag, index, word}.
  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [CFG_ADDR_WIDTH-1:0] addr);
    return addr[CFG_ADDR_WIDTH-1 -: TAG_WIDTH];
  endfunction

  function automatic logic [CFG_INDEX_WIDTH-1:0] addr_index(input logic [CFG_ADDR_WIDTH-1:0] addr);
    return addr[CFG_WORD_BITS +: CFG_INDEX_WIDTH];
  endfunction

  function automatic logic [CFG_WORD_BITS-1:0] addr_word(input logic [CFG_ADDR_WIDTH-1:0] addr);
    return addr[CFG_WORD_BITS-1:0];
  endfunction

endpackage

// File: rtl/cache_controller_tag_store.sv
// Tag array plus valid/dirty vectors; combinational read, one write port for fills and dirty marking.
module tag_store #(
  parameter int INDEX_WIDTH = 9,
  parameter int TAG_W       = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic [TAG_W-1:0]       rd_tag,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic                   fill_en,
  input  logic [TAG_W-1:0]       fill_tag,
  input  logic                   dirty_set
);

  localparam int LINES = 2 ** INDEX_WIDTH;

  logic [TAG_W-1:0] tags [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  // Tags need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (fill_en) tags[wr_index] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= 1'b0;
    end else if (dirty_set) begin
      dirty_q[wr_index] <= 1'b1;
    end
  end

  assign rd_tag   = tags[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back write-allocate cache controller: tag/valid/dirty state, data-array
// sequencing over word port A and line port B, and line-wide requests to the next memory level.
module cache_controller
  import cache_pkg::*;
#(
  parameter int  DATA_WIDTH  = CFG_DATA_WIDTH,
  parameter int  INDEX_WIDTH = CFG_INDEX_WIDTH,
  parameter int  WORD_BITS   = CFG_WORD_BITS,
  parameter int  ADDR_WIDTH  = CFG_ADDR_WIDTH,
  localparam int TAG_W       = ADDR_WIDTH - INDEX_WIDTH - WORD_BITS,
  localparam int LINE_W      = DATA_WIDTH * (2 ** WORD_BITS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_req_valid,
  output logic                        cpu_req_ready,
  input  logic                        cpu_req_we,
  input  logic [ADDR_WIDTH-1:0]       cpu_req_addr,
  input  logic [DATA_WIDTH-1:0]       cpu_req_wdata,
  output logic                        cpu_resp_valid,
  output logic [DATA_WIDTH-1:0]       cpu_resp_rdata,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [ADDR_WIDTH-WORD_BITS-1:0] mem_req_addr,
  output logic [LINE_W-1:0]           mem_req_wdata,
  input  logic                        mem_resp_valid,
  input  logic [LINE_W-1:0]           mem_resp_rdata,
  output logic [INDEX_WIDTH-1:0]      arr_addr_a,
  output logic [WORD_BITS-1:0]        arr_word_a,
  output logic [DATA_WIDTH-1:0]       arr_data_a,
  output logic                        arr_we_a,
  input  logic [DATA_WIDTH-1:0]       arr_q_a,
  output logic [INDEX_WIDTH-1:0]      arr_addr_b,
  output logic [LINE_W-1:0]           arr_data_b,
  output logic                        arr_we_b,
  input  logic [LINE_W-1:0]           arr_q_b
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the initiator holds every request field constant from raising valid until that edge.

  state_e state, state_next;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [LINE_W-1:0]     victim;
  logic [TAG_W-1:0]      victim_tag;

  logic [INDEX_WIDTH-1:0] req_index, cpu_index;
  logic [WORD_BITS-1:0]   req_word, cpu_word;
  logic [TAG_W-1:0]       req_tag;

  logic [TAG_W-1:0] st_tag;
  logic             st_valid, st_dirty, hit;

  logic accept, latch_victim, fill_en, dirty_set;

  assign req_index = req_addr[WORD_BITS +: INDEX_WIDTH];
  assign req_word  = req_addr[WORD_BITS-1:0];
  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign cpu_index = cpu_req_addr[WORD_BITS +: INDEX_WIDTH];
  assign cpu_word  = cpu_req_addr[WORD_BITS-1:0];
  assign hit       = st_valid && (st_tag == req_tag);

  tag_store #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_W       (TAG_W)
  ) u_tag_store (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (req_index),
    .rd_tag    (st_tag),
    .rd_valid  (st_valid),
    .rd_dirty  (st_dirty),
    .wr_index  (req_index),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .dirty_set (dirty_set)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr  <= cpu_req_addr;
      req_we    <= cpu_req_we;
      req_wdata <= cpu_req_wdata;
    end
    if (latch_victim) begin
      victim     <= arr_q_b;
      victim_tag <= st_tag;
    end
  end

  // Everything is forced to zero while reset is high so the array and memory see no stray traffic.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    latch_victim   = 1'b0;
    fill_en        = 1'b0;
    dirty_set      = 1'b0;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    arr_addr_a     = '0;
    arr_word_a     = '0;
    arr_data_a     = '0;
    arr_we_a       = 1'b0;
    arr_addr_b     = '0;
    arr_data_b     = '0;
    arr_we_b       = 1'b0;

    if (!reset) begin
      if (state != IDLE) begin
        arr_addr_a = req_index;
        arr_word_a = req_word;
        arr_addr_b = req_index;
      end

      case (state)
        IDLE: begin
          cpu_req_ready = 1'b1;
          arr_addr_a    = cpu_index;
          arr_word_a    = cpu_word;
          arr_addr_b    = cpu_index;
          if (cpu_req_valid) begin
            accept     = 1'b1;
            state_next = LOOKUP;
          end
        end

        LOOKUP: begin
          if (hit) begin
            cpu_resp_valid = 1'b1;
            if (req_we) begin
              arr_we_a       = 1'b1;
              arr_data_a     = req_wdata;
              dirty_set      = 1'b1;
              cpu_resp_rdata = req_wdata;
            end else begin
              cpu_resp_rdata = arr_q_a;
            end
            state_next = IDLE;
          end else if (st_valid && st_dirty) begin
            latch_victim = 1'b1;
            state_next   = WB_REQ;
          end else begin
            state_next = FILL_REQ;
          end
        end

        WB_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_we    = 1'b1;
          mem_req_addr  = {victim_tag, req_index};
          mem_req_wdata = victim;
          if (mem_req_ready) state_next = FILL_REQ;
        end

        FILL_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = {req_tag, req_index};
          if (mem_req_ready) state_next = FILL_WAIT;
        end

        FILL_WAIT: begin
          if (mem_resp_valid) begin
            arr_we_b   = 1'b1;
            arr_data_b = mem_resp_rdata;
            fill_en    = 1'b1;
            state_next = REPLAY;
          end
        end

        // Re-reads the word from the freshly filled line so LOOKUP sees it on arr_q_a.
        REPLAY: state_next = LOOKUP;

        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: data-array and memory environment, word-level reference model,
// directed steps followed by randomized requests.
module tb_cache_controller;

  localparam int DW = 32;
  localparam int IW = 9;
  localparam int WB = 3;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_ready;
  logic          cpu_req_we = 1'b0;
  logic [AW-1:0] cpu_req_addr = '0;
  logic [DW-1:0] cpu_req_wdata = '0;
  logic          cpu_resp_valid;
  logic [DW-1:0] cpu_resp_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_req_we;
  logic [AW-WB-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_resp_valid = 1'b0;
  logic [LW-1:0] mem_resp_rdata = '0;
  logic [IW-1:0] arr_addr_a;
  logic [WB-1:0] arr_word_a;
  logic [DW-1:0] arr_data_a;
  logic          arr_we_a;
  logic [DW-1:0] arr_q_a;
  logic [IW-1:0] arr_addr_b;
  logic [LW-1:0] arr_data_b;
  logic          arr_we_b;
  logic [LW-1:0] arr_q_b;

  int checks = 0;
  int errors = 0;

  cache_controller dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .arr_addr_a     (arr_addr_a),
    .arr_word_a     (arr_word_a),
    .arr_data_a     (arr_data_a),
    .arr_we_a       (arr_we_a),
    .arr_q_a        (arr_q_a),
    .arr_addr_b     (arr_addr_b),
    .arr_data_b     (arr_data_b),
    .arr_we_b       (arr_we_b),
    .arr_q_b        (arr_q_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- data array (environment) ----------------
  logic [LW-1:0] arr_mem [512];
  always @(posedge clk) begin
    if (arr_we_a) arr_mem[arr_addr_a][arr_word_a*32 +: 32] <= arr_data_a;
    if (arr_we_b) arr_mem[arr_addr_b] <= arr_data_b;
    arr_q_a <= arr_mem[arr_addr_a][arr_word_a*32 +: 32];
    arr_q_b <= arr_mem[arr_addr_b];
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] mem_words [int unsigned];   // next-level memory contents
  logic [DW-1:0] gold [int unsigned];        // latest CPU-visible value
  bit            mval [512];
  bit            mdirty [512];
  logic [19:0]   mtag [512];

  function automatic logic [DW-1:0] init_word(input int unsigned a);
    if (a >= 32'h100 && a <= 32'h107) return 32'h1000 + (a - 32'h100);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] mem_val(input int unsigned a);
    if (mem_words.exists(a)) return mem_words[a];
    return init_word(a);
  endfunction

  function automatic logic [DW-1:0] rd_exp(input int unsigned a);
    if (gold.exists(a)) return gold[a];
    return mem_val(a);
  endfunction

  function automatic int unsigned line_base(input int unsigned tg, input int unsigned idx);
    return tg * 4096 + idx * 8;
  endfunction

  function automatic logic [LW-1:0] gold_line(input int unsigned tg, input int unsigned idx);
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = rd_exp(line_base(tg, idx) + k);
    return l;
  endfunction

  function automatic logic [LW-1:0] mem_line(input int unsigned tg, input int unsigned idx);
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = mem_val(line_base(tg, idx) + k);
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 512; i++) begin
      mval[i]   = 1'b0;
      mdirty[i] = 1'b0;
    end
    gold.delete();
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) chk("we_a_b_exclusive", arr_we_a & arr_we_b, 1'b0);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // One CPU request from IDLE through its response; called and returning at a negedge.
  task automatic do_req(input bit we, input int unsigned addr, input logic [DW-1:0] wd,
                        input int stall, input int fdly, input bit abort);
    int unsigned idx, tg;
    bit hit, wb;
    logic [DW-1:0] exp;
    idx = (addr / 8) % 512;
    tg  = addr / 4096;
    hit = mval[idx] && (mtag[idx] == tg);
    wb  = !hit && mval[idx] && mdirty[idx];

    chk("req_ready_idle", cpu_req_ready, 1'b1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wd;
    tick();
    cpu_req_valid = 1'b0;
    chk("ready_low_busy", cpu_req_ready, 1'b0);

    if (!hit) begin
      chk("miss_no_resp", cpu_resp_valid, 1'b0);
      tick();
      chk("mem_req_latency", mem_req_valid, 1'b1);
      if (wb) begin
        chk("wb_we", mem_req_we, 1'b1);
        chk("wb_addr", mem_req_addr, (mtag[idx] * 512 + idx));
        chk("wb_data", mem_req_wdata, gold_line(mtag[idx], idx));
        for (int s = 0; s < stall; s++) begin
          tick();
          chk("wb_hold_valid", mem_req_valid, 1'b1);
          chk("wb_hold_addr", mem_req_addr, (mtag[idx] * 512 + idx));
          chk("wb_hold_data", mem_req_wdata, gold_line(mtag[idx], idx));
          chk("wb_hold_ready", cpu_req_ready, 1'b0);
        end
        for (int k = 0; k < 8; k++)
          mem_words[line_base(mtag[idx], idx) + k] = rd_exp(line_base(mtag[idx], idx) + k);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("fill_after_wb", mem_req_valid, 1'b1);
      end
      chk("fill_we", mem_req_we, 1'b0);
      chk("fill_addr", mem_req_addr, (tg * 512 + idx));
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      for (int d = 0; d < fdly; d++) begin
        chk("fill_wait_quiet", mem_req_valid, 1'b0);
        tick();
      end
      if (abort) begin
        reset = 1'b1;
        tick();
        chk("abort_mem_valid", mem_req_valid, 1'b0);
        chk("abort_no_resp", cpu_resp_valid, 1'b0);
        reset = 1'b0;
        tick();
        chk("abort_ready", cpu_req_ready, 1'b1);
        model_reset();
        return;
      end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = mem_line(tg, idx);
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      chk("replay_no_resp", cpu_resp_valid, 1'b0);
      tick();
      mval[idx]   = 1'b1;
      mtag[idx]   = tg;
      mdirty[idx] = 1'b0;
    end

    exp = we ? wd : rd_exp(addr);
    chk(hit ? "hit_resp_valid" : "miss_resp_valid", cpu_resp_valid, 1'b1);
    chk(hit ? "hit_rdata" : "miss_rdata", cpu_resp_rdata, exp);
    chk("resp_mem_idle", mem_req_valid, 1'b0);
    if (we) begin
      gold[addr]  = wd;
      mdirty[idx] = 1'b1;
    end
    tick();
    chk("resp_single_pulse", cpu_resp_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned idx_pool [4];
    int unsigned tag_pool [4];
    idx_pool[0] = 0; idx_pool[1] = 32'h20; idx_pool[2] = 32'h21; idx_pool[3] = 32'h1FF;
    tag_pool[0] = 0; tag_pool[1] = 1;      tag_pool[2] = 2;      tag_pool[3] = 32'hFFFFF;
    model_reset();
    for (int i = 0; i < 512; i++) arr_mem[i] = '0;

    cpu_req_addr  = 32'h1234;
    cpu_req_valid = 1'b1;
    repeat (3) tick();
    chk("rst_ready", cpu_req_ready, 1'b0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_resp", cpu_resp_valid, 1'b0);
    chk("rst_arr_addr_a", arr_addr_a, 1'b0);
    chk("rst_arr_we", {arr_we_a, arr_we_b}, 2'b00);
    cpu_req_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_rst_ready", cpu_req_ready, 1'b1);

    do_req(1'b0, 32'h100, '0, 0, 2, 1'b0);            // clean miss, 0x1000
    do_req(1'b0, 32'h103, '0, 0, 0, 1'b0);            // hit, 0x1003
    do_req(1'b1, 32'h105, 32'hDEADBEEF, 0, 0, 1'b0);  // write hit
    do_req(1'b0, 32'h105, '0, 0, 0, 1'b0);            // reads back DEADBEEF
    do_req(1'b0, 32'h1100, '0, 10, 1, 1'b0);          // dirty miss, stalled writeback
    do_req(1'b0, 32'h2100, '0, 0, 2, 1'b1);           // reset during FILL_WAIT
    do_req(1'b0, 32'h100, '0, 0, 0, 1'b0);            // misses again after reset
    do_req(1'b0, 32'h105, '0, 0, 0, 1'b0);            // written-back DEADBEEF

    for (int n = 0; n < 200; n++) begin
      int unsigned a;
      a = line_base(tag_pool[$urandom_range(0, 3)], idx_pool[$urandom_range(0, 3)])
          + $urandom_range(0, 7);
      do_req($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
